// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the arbiter and the FIFO.
//   req       : per-requester beat-pending flags
//   req_data  : packed per-requester data, slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   gnt       : one-hot grant; a beat moves when gnt[i]=1 at the rising edge
//   full      : FIFO full flag
//   wr_cs     : FIFO write chip select
//   wr_en     : FIFO write enable
//   data_in   : FIFO write data
//   owner     : index of the current burst owner (meaningful while busy=1)
//   busy      : arbiter is holding a burst
// The master modport is the arbiter side; slave is the producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          full;
    logic                          wr_cs;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [OWNER_W-1:0]            owner;
    logic                          busy;

    modport master (
        input  req, req_data, full,
        output gnt, wr_cs, wr_en, data_in, owner, busy
    );

    modport slave (
        output req, req_data, full,
        input  gnt, wr_cs, wr_en, data_in, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ
// requesters. A winner may keep the port for up to MAX_BURST consecutive
// beats before handing it on; the hand-over happens in the same cycle, so a
// continuously requesting population never sees a bubble.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous reset, active low
//   bus  : fifo_wr_arbiter_if.master (req/req_data/full in, gnt/wr_cs/wr_en/
//          data_in/owner/busy out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no burst owner; grant the round-robin pick when not full
// OWN   | owner holds the port; extend burst or re-arbitrate on release
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);
    localparam int             OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]     MAX_CNT = 4'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   last_q, last_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 wr_cs_q;

    logic                 pick_valid;
    logic [OWNER_W-1:0]   pick_idx;
    logic [OWNER_W-1:0]   scan_idx;
    logic                 release_burst;
    logic [NUM_REQ-1:0]   gnt_int;
    logic [DATA_WIDTH-1:0] data_mux;

    // Round-robin pick starting at last+1. The loop walks the scan order
    // backwards so the earliest requester in scan order is written last and
    // wins. In OWN, last always equals owner, so the owner naturally lands at
    // the end of the scan and is only chosen when nobody else requests.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = OWNER_W'((int'(last_q) + k) % NUM_REQ);
            if (bus.req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        burst_cnt_d   = burst_cnt_q;
        gnt_int       = '0;
        release_burst = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.full && pick_valid) begin
                    gnt_int[pick_idx] = 1'b1;
                    last_d            = pick_idx;
                    if (MAX_BURST > 1) begin
                        state_d     = OWN;
                        owner_d     = pick_idx;
                        burst_cnt_d = 4'd1;
                    end
                end
            end
            OWN: begin
                release_burst = !bus.req[owner_q] || (burst_cnt_q == MAX_CNT);
                if (!release_burst) begin
                    // full stalls the burst with owner and count held
                    if (!bus.full) begin
                        gnt_int[owner_q] = 1'b1;
                        burst_cnt_d      = burst_cnt_q + 4'd1;
                    end
                end else if (!bus.full && pick_valid) begin
                    gnt_int[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    last_d            = pick_idx;
                    burst_cnt_d       = 4'd1;
                end else begin
                    // a release is never deferred, even while full
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_int[i]) begin
                data_mux = data_mux | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= OWNER_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            wr_cs_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            wr_cs_q     <= 1'b1;
        end
    end

    // Outputs are masked combinationally while reset is held so nothing is
    // granted before the registered state has been cleared.
    assign bus.gnt     = rst ? gnt_int : '0;
    assign bus.wr_en   = rst & (|gnt_int) & wr_cs_q;
    assign bus.data_in = rst ? data_mux : '0;
    assign bus.busy    = rst & (state_q == OWN);
    assign bus.owner   = owner_q;
    assign bus.wr_cs   = wr_cs_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [7:0] exp_q[$];
    logic [3:0] exp_gnt_q[$];
    logic [7:0] exp_d;
    logic [3:0] exp_g;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.req      = 4'b1111;
        bus.full     = 1'b0;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        repeat (3) begin
            tick();
            checks++;
            if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
            checks++;
            if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
            checks++;
            if (bus.wr_cs !== 1'b0) begin errors++; $display("FAIL reset_wr_cs: got %b expected 0", bus.wr_cs); end
            checks++;
            if (bus.busy !== 1'b0 || bus.data_in !== 8'h00) begin
                errors++; $display("FAIL reset_busy_data: got busy=%b data=%h expected 0/00", bus.busy, bus.data_in);
            end
        end
        checks++;
        if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
        rst     = 1'b1;
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.wr_cs !== 1'b0) begin errors++; $display("FAIL wr_cs_before_edge: got %b expected 0", bus.wr_cs); end
        tick();
        checks++;
        if (bus.wr_cs !== 1'b1) begin errors++; $display("FAIL wr_cs_after_release: got %b expected 1", bus.wr_cs); end
    endtask

    task automatic test_round_robin();
        for (int b = 0; b < 20; b++) begin
            exp_q.push_back(8'hA0 + 8'((b / 4) % 4));
            exp_gnt_q.push_back(4'b0001 << ((b / 4) % 4));
        end
        bus.req      = 4'b1111;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int b = 0; b < 20; b++) begin
            #1;
            exp_d = exp_q.pop_front();
            exp_g = exp_gnt_q.pop_front();
            checks++;
            if (bus.data_in !== exp_d) begin errors++; $display("FAIL rr_data beat %0d: got %h expected %h", b, bus.data_in, exp_d); end
            checks++;
            if (bus.gnt !== exp_g || !$onehot(bus.gnt)) begin
                errors++; $display("FAIL rr_gnt beat %0d: got %b expected %b", b, bus.gnt, exp_g);
            end
            checks++;
            if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en beat %0d: got %b expected 1", b, bus.wr_en); end
            tick();
        end
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_idle_gnt: got %b expected 0000", bus.gnt); end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_drop();
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC2);
        bus.req      = 4'b0100;
        bus.req_data = {8'h00, 8'hC2, 8'h00, 8'h00};
        for (int b = 0; b < 2; b++) begin
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (bus.gnt !== 4'b0100 || bus.data_in !== exp_d) begin
                errors++; $display("FAIL drop_beat %0d: got gnt=%b data=%h expected 0100/%h", b, bus.gnt, bus.data_in, exp_d);
            end
            tick();
            checks++;
            if (bus.busy !== 1'b1 || bus.owner !== 2'd2) begin
                errors++; $display("FAIL drop_owner %0d: got busy=%b owner=%0d expected 1/2", b, bus.busy, bus.owner);
            end
        end
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0) begin
            errors++; $display("FAIL drop_release: got gnt=%b wr_en=%b expected 0000/0", bus.gnt, bus.wr_en);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_full_stall();
        repeat (4) exp_q.push_back(8'hB1);
        bus.req      = 4'b0010;
        bus.req_data = {8'h00, 8'h00, 8'hB1, 8'h00};
        for (int b = 0; b < 2; b++) begin
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (bus.gnt !== 4'b0010 || bus.data_in !== exp_d) begin
                errors++; $display("FAIL stall_pre_beat %0d: got gnt=%b data=%h expected 0010/%h", b, bus.gnt, bus.data_in, exp_d);
            end
            tick();
        end
        bus.full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0) begin
                errors++; $display("FAIL stall_gnt cycle %0d: got gnt=%b wr_en=%b expected 0000/0", c, bus.gnt, bus.wr_en);
            end
            checks++;
            if (bus.owner !== 2'd1 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL stall_owner cycle %0d: got owner=%0d busy=%b expected 1/1", c, bus.owner, bus.busy);
            end
            tick();
        end
        bus.full = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (bus.gnt !== 4'b0010 || bus.data_in !== exp_d || bus.wr_en !== 1'b1) begin
                errors++; $display("FAIL stall_post_beat %0d: got gnt=%b data=%h expected 0010/%h", b, bus.gnt, bus.data_in, exp_d);
            end
            tick();
        end
        // burst now exhausted: another requester must take over at once
        bus.req = 4'b1010;
        #1;
        checks++;
        if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL stall_handover: got %b expected 1000", bus.gnt); end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] mem [8];
        int         cnt;
        int         viol;
        logic [7:0] d0, d2, wd;
        logic [3:0] g;
        logic       we;
        cnt  = 0;
        viol = 0;
        d0   = 8'h10;
        d2   = 8'h20;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.full = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h20 + 8'(k));
        bus.req      = 4'b0101;
        bus.req_data = {8'h00, d2, 8'h00, d0};
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.wr_en && bus.full) viol++;
            g  = bus.gnt;
            we = bus.wr_en;
            wd = bus.data_in;
            @(posedge clk);
            if (we && !bus.full && cnt < 8) begin
                mem[cnt] = wd;
                cnt++;
            end
            if (g[0]) d0 = d0 + 8'd1;
            if (g[2]) d2 = d2 + 8'd1;
            #1;
            bus.req_data = {8'h00, d2, 8'h00, d0};
            bus.full     = (cnt == 8);
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL fill_wr_en_while_full: got %0d writes expected 0", viol); end
        checks++;
        if (cnt != 8) begin errors++; $display("FAIL fill_count: got %0d writes expected 8", cnt); end
        #1;
        checks++;
        if (bus.full !== 1'b1 || bus.wr_en !== 1'b0 || bus.gnt !== 4'b0000) begin
            errors++; $display("FAIL fill_final: got full=%b wr_en=%b gnt=%b expected 1/0/0000", bus.full, bus.wr_en, bus.gnt);
        end
        for (int i = 0; i < 8; i++) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (mem[i] !== exp_d) begin errors++; $display("FAIL fill_entry %0d: got %h expected %h", i, mem[i], exp_d); end
        end
        bus.full = 1'b0;
        bus.req  = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        bus.req      = 4'b1000;
        bus.req_data = {8'hD3, 8'h00, 8'h00, 8'hE0};
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b1000 || bus.data_in !== 8'hD3) begin
                errors++; $display("FAIL midrst_beat %0d: got gnt=%b data=%h expected 1000/d3", b, bus.gnt, bus.data_in);
            end
            tick();
        end
        checks++;
        if (bus.owner !== 2'd3 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL midrst_owner: got owner=%0d busy=%b expected 3/1", bus.owner, bus.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.data_in !== 8'h00) begin
            errors++; $display("FAIL midrst_mask: got gnt=%b wr_en=%b busy=%b data=%h expected 0", bus.gnt, bus.wr_en, bus.busy, bus.data_in);
        end
        tick();
        checks++;
        if (bus.wr_cs !== 1'b0 || bus.owner !== 2'd0) begin
            errors++; $display("FAIL midrst_state: got wr_cs=%b owner=%0d expected 0/0", bus.wr_cs, bus.owner);
        end
        rst     = 1'b1;
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1001;
        #1;
        checks++;
        if (bus.gnt !== 4'b0001 || bus.data_in !== 8'hE0 || bus.wr_en !== 1'b1) begin
            errors++; $display("FAIL midrst_first_grant: got gnt=%b data=%h wr_en=%b expected 0001/e0/1", bus.gnt, bus.data_in, bus.wr_en);
        end
        tick();
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.full     = 1'b0;
        test_reset();
        test_round_robin();
        test_single_drop();
        test_full_stall();
        test_fifo_fill();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
